// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_pkg
// Description : Shared types, register addresses and the fixed-priority
//               encoder for the interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package int_pkg;

    localparam int INT_N_SRC = 4;
    localparam int INT_ID_W  = $clog2(INT_N_SRC);

    localparam logic [1:0] INT_MASK_ADDR = 2'd0;
    localparam logic [1:0] INT_PEND_ADDR = 2'd1;
    localparam logic [1:0] INT_ISR_ADDR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    // Highest set index wins; later iterations overwrite earlier ones.
    function automatic logic [4:0] prio_enc(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : int_arbiter_if
// Description : Configuration bus and CP0 request/ack/return handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface int_arbiter_if
    import int_pkg::*;
#(
    parameter int ID_W = INT_ID_W
);
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            int_req;
    logic [ID_W-1:0] int_id;
    logic            int_ack;
    logic            int_ret;
    logic            in_service;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, int_ack, int_ret,
        input  cfg_rdata, int_req, int_id, in_service
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_ret,
        output cfg_rdata, int_req, int_id, in_service
    );
endinterface
`default_nettype wire

// File: rtl/irq_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_sync
// Description : Synchroniser chain plus registered rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      edge_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   prev_q;
    logic                   edge_q;

    // arm_q holds off detection until prev_q carries a real sample, so a
    // level that was already high across reset is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            arm_q  <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q & arm_q[SYNC_STAGES];
        end
    end

    assign edge_o = edge_q;
endmodule
`default_nettype wire

// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : int_arbiter
// Description : Interrupt sequencer: sticky pending, mask, fixed priority and
//               a single-outstanding request/ack/return handshake to CP0.
// Revision    : 1.0 - initial release
// ============================================================================
module int_arbiter
    import int_pkg::*;
#(
    parameter int N_SRC       = INT_N_SRC,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(N_SRC)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [N_SRC-1:0] irq_src,
    int_arbiter_if.slave          bus
);
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_elig;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  isr_q, isr_d;
    logic [ID_W-1:0]  w_win;
    logic             w_ack_take;
    int_state_t       state_q, state_d;

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            irq_edge_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .rst    (rst),
                .d      (irq_src[i]),
                .edge_o (w_edge[i])
            );
        end
    endgenerate

    generate
        if (N_SRC < 32) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^bus.cfg_wdata[31:N_SRC];
        end
    endgenerate

    assign w_elig = pend_q & mask_q;
    assign w_win  = ID_W'(prio_enc(32'(w_elig)));

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        isr_d      = isr_q;
        w_ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (|w_elig) begin
                    id_d    = w_win;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Ack is checked first so it wins over a coincident withdrawal.
                if (bus.int_ack) begin
                    w_ack_take = 1'b1;
                    isr_d      = id_q;
                    state_d    = SERVICE;
                end else if (!mask_q[id_q] || !pend_q[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.int_ret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        if (bus.cfg_we && bus.cfg_addr == INT_MASK_ADDR) begin
            mask_d = bus.cfg_wdata[N_SRC-1:0];
        end
        if (bus.cfg_we && bus.cfg_addr == INT_PEND_ADDR) begin
            pend_d = pend_d & ~bus.cfg_wdata[N_SRC-1:0];
        end
        if (w_ack_take) pend_d[id_q] = 1'b0;
        // Edge set is applied last so it overrides both clears.
        pend_d = pend_d | w_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            id_q    <= '0;
            isr_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            isr_q   <= isr_d;
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            INT_MASK_ADDR: bus.cfg_rdata[N_SRC-1:0] = mask_q;
            INT_PEND_ADDR: bus.cfg_rdata[N_SRC-1:0] = pend_q;
            INT_ISR_ADDR:  bus.cfg_rdata[ID_W-1:0]  = isr_q;
            default:       bus.cfg_rdata = '0;
        endcase
    end

    assign bus.int_req    = (state_q == REQ);
    assign bus.int_id     = id_q;
    assign bus.in_service = (state_q == SERVICE);
endmodule
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_arbiter
// Description : Directed self-checking bench for int_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_arbiter;
    import int_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_src;
    logic [31:0] rv;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    int_arbiter_if #(.ID_W(2)) bus ();

    int_arbiter #(
        .N_SRC       (4),
        .SYNC_STAGES (2),
        .ID_W        (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        bus.cfg_addr = a;
        #1;
        rv = bus.cfg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step();
        bus.cfg_we    = 1'b0;
        bus.cfg_wdata = '0;
    endtask

    task automatic pulse_src(input logic [3:0] m);
        irq_src = m;
        step();
        irq_src = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0h want 0", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0h want 0", bus.int_id); end
        n_cmp++; if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL rst_insvc: got %0h want 0", bus.in_service); end
        rst = 1'b0;
        step();
        step();
        step();
        rd(INT_MASK_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rst_mask: got %0h want 0", rv); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rst_pend: got %0h want 0", rv); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rst_isr: got %0h want 0", rv); end
        rd(2'd3);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL addr3: got %0h want 0", rv); end
    endtask

    task automatic test_latency();
        wr(INT_MASK_ADDR, 32'hF);
        pulse_src(4'b0010);
        step();
        step();
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL lat_pend_early: got %0h want 0", rv); end
        step();
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h2) begin n_err++; $display("FAIL lat_pend: got %0h want 2", rv); end
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL lat_req_early: got %0h want 0", bus.int_req); end
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL lat_req: got %0h want 1", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd1) begin n_err++; $display("FAIL lat_id: got %0h want 1", bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL ack_req: got %0h want 0", bus.int_req); end
        n_cmp++; if (bus.in_service !== 1'b1) begin n_err++; $display("FAIL ack_insvc: got %0h want 1", bus.in_service); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h1) begin n_err++; $display("FAIL ack_isr: got %0h want 1", rv); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL ack_pend: got %0h want 0", rv); end
        bus.int_ret = 1'b1;
        step();
        bus.int_ret = 1'b0;
        n_cmp++; if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL ret_insvc: got %0h want 0", bus.in_service); end
    endtask

    task automatic test_priority();
        pulse_src(4'b1001);
        step();
        step();
        step();
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h9) begin n_err++; $display("FAIL pri_pend: got %0h want 9", rv); end
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL pri_req: got %0h want 1", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd3) begin n_err++; $display("FAIL pri_id: got %0h want 3", bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h1) begin n_err++; $display("FAIL pri_pend_svc: got %0h want 1", rv); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h3) begin n_err++; $display("FAIL pri_isr: got %0h want 3", rv); end
        step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL pri_noreq_svc: got %0h want 0", bus.int_req); end
        bus.int_ret = 1'b1;
        step();
        bus.int_ret = 1'b0;
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL pri_req_idle: got %0h want 0", bus.int_req); end
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL pri_req2: got %0h want 1", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd0) begin n_err++; $display("FAIL pri_id2: got %0h want 0", bus.int_id); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h1) begin n_err++; $display("FAIL pri_pend2: got %0h want 1", rv); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL pri_pend3: got %0h want 0", rv); end
        bus.int_ret = 1'b1;
        step();
        bus.int_ret = 1'b0;
    endtask

    task automatic test_mask_enable();
        wr(INT_MASK_ADDR, 32'h1);
        pulse_src(4'b0100);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL msk_noreq: got %0h want 0", bus.int_req); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h4) begin n_err++; $display("FAIL msk_pend: got %0h want 4", rv); end
        wr(INT_MASK_ADDR, 32'h5);
        rd(INT_MASK_ADDR);
        n_cmp++; if (rv !== 32'h5) begin n_err++; $display("FAIL msk_rd: got %0h want 5", rv); end
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL msk_req_early: got %0h want 0", bus.int_req); end
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL msk_req: got %0h want 1", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd2) begin n_err++; $display("FAIL msk_id: got %0h want 2", bus.int_id); end
    endtask

    task automatic test_withdraw();
        wr(INT_MASK_ADDR, 32'h0);
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL wd_req_hold: got %0h want 1", bus.int_req); end
        step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL wd_req: got %0h want 0", bus.int_req); end
        n_cmp++; if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL wd_insvc: got %0h want 0", bus.in_service); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h4) begin n_err++; $display("FAIL wd_pend: got %0h want 4", rv); end
        wr(INT_MASK_ADDR, 32'h4);
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL wd_rereq: got %0h want 1", bus.int_req); end
        bus.int_ack   = 1'b1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = INT_PEND_ADDR;
        bus.cfg_wdata = 32'h4;
        step();
        bus.int_ack   = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_wdata = '0;
        n_cmp++; if (bus.in_service !== 1'b1) begin n_err++; $display("FAIL wd_ackwin: got %0h want 1", bus.in_service); end
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL wd_ackreq: got %0h want 0", bus.int_req); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h2) begin n_err++; $display("FAIL wd_isr: got %0h want 2", rv); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL wd_pend2: got %0h want 0", rv); end
    endtask

    task automatic test_service();
        wr(INT_MASK_ADDR, 32'hC);
        pulse_src(4'b1000);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL svc_noreq: got %0h want 0", bus.int_req); end
        n_cmp++; if (bus.in_service !== 1'b1) begin n_err++; $display("FAIL svc_insvc: got %0h want 1", bus.in_service); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h8) begin n_err++; $display("FAIL svc_pend: got %0h want 8", rv); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.in_service !== 1'b1) begin n_err++; $display("FAIL svc_stray_ack: got %0h want 1", bus.in_service); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h8) begin n_err++; $display("FAIL svc_pend2: got %0h want 8", rv); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h2) begin n_err++; $display("FAIL svc_isr: got %0h want 2", rv); end
        bus.int_ret = 1'b1;
        step();
        bus.int_ret = 1'b0;
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL svc_ret_req: got %0h want 0", bus.int_req); end
        step();
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL svc_req3: got %0h want 1", bus.int_req); end
        n_cmp++; if (bus.int_id !== 2'd3) begin n_err++; $display("FAIL svc_id3: got %0h want 3", bus.int_id); end
        bus.int_ret = 1'b1;
        step();
        bus.int_ret = 1'b0;
        n_cmp++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL svc_stray_ret: got %0h want 1", bus.int_req); end
    endtask

    task automatic test_reset_mid();
        irq_src = 4'b0001;
        rst     = 1'b1;
        step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL rreq_req: got %0h want 0", bus.int_req); end
        n_cmp++; if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL rreq_insvc: got %0h want 0", bus.in_service); end
        rd(INT_MASK_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rreq_mask: got %0h want 0", rv); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rreq_pend: got %0h want 0", rv); end
        rst = 1'b0;
        wr(INT_MASK_ADDR, 32'hF);
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL lvl_noreq: got %0h want 0", bus.int_req); end
        rd(INT_PEND_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL lvl_pend: got %0h want 0", rv); end
        irq_src = '0;
        step();
        pulse_src(4'b0100);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.int_id !== 2'd2 || bus.int_req !== 1'b1) begin n_err++; $display("FAIL rsvc_req: got req %0h id %0h want req 1 id 2", bus.int_req, bus.int_id); end
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        n_cmp++; if (bus.in_service !== 1'b1) begin n_err++; $display("FAIL rsvc_insvc0: got %0h want 1", bus.in_service); end
        rst = 1'b1;
        step();
        n_cmp++; if (bus.in_service !== 1'b0) begin n_err++; $display("FAIL rsvc_insvc: got %0h want 0", bus.in_service); end
        n_cmp++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL rsvc_req0: got %0h want 0", bus.int_req); end
        rd(INT_ISR_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rsvc_isr: got %0h want 0", rv); end
        rd(INT_MASK_ADDR);
        n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL rsvc_mask: got %0h want 0", rv); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst           = 1'b1;
        irq_src       = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.int_ack   = 1'b0;
        bus.int_ret   = 1'b0;
        test_reset();
        test_latency();
        test_priority();
        test_mask_enable();
        test_withdraw();
        test_service();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
